div32_seq: RTL and testbench
============================

# div32_seq

Iterative 32-bit integer divider for the RV32M datapath, the counterpart of the combinational `mul32` multiplier. It computes quotient and remainder for DIV/DIVU/REM/REMU using a radix-2 restoring algorithm over 32 iterations, with a start/valid handshake. It sits beside the multiplier in the ALU sub-tree, and the pipeline stalls on `busy`.

## Interface
- No parameters; widths are fixed at 32 bits.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `signed_op` in 1: 1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- `a` in 32: dividend; sampled with `start`.
- `b` in 32: divisor; sampled with `start`.
- `busy` out 1: high while an operation is in flight.
- `valid` out 1: one-cycle pulse; `quo`/`rem` are valid.
- `quo` out 32: quotient, registered.
- `rem` out 32: remainder, registered.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start`=1 latches operands, `signed_op`, and the result signs.
  - Signed case: quotient negative iff sign(a)≠sign(b); remainder takes sign(a).
  - Loads |a| and |b| for signed ops, raw values for unsigned.
  - Sets the iteration counter to 31 and goes to CALC.
- **CALC**
  - Each cycle: partial remainder P = {P[31:0], Q[31]}, shift Q left.
  - If P ≥ divisor: P -= divisor and Q[0] = 1.
  - P is 33 bits so the compare never overflows.
  - The counter decrements; at 0, go to FIX.
- **FIX**
  - Applies the sign correction (two's-complement negate) to Q and P.
  - Writes `quo`/`rem`, then goes to DONE.
- **DONE**
  - `valid`=1 for exactly one cycle; always returns to IDLE next.
- **Special cases (RISC-V mandated)**
  - b=0: `quo`=0xFFFFFFFF, `rem`=a, for both signed and unsigned.
  - Signed a=0x80000000 with b=0xFFFFFFFF: `quo`=0x80000000, `rem`=0.
- `start` outside IDLE (CALC/FIX/DONE) is ignored: no queueing, no effect on the current operation.
- `quo`/`rem` hold their last result until the next FIX (or fast-path load) overwrites them.
- Reset at any point: state=IDLE, counter=0, `busy`=0, `valid`=0, `quo`=0, `rem`=0, internal P/Q cleared; any in-flight operation is discarded.

## Timing
- `start` sampled at edge T.
- CALC occupies cycles T+1..T+32; FIX is cycle T+33.
- DONE and `valid` are high in cycle T+34, so normal latency is 34 cycles.
- `busy` is high from T+1 through T+33 and low in DONE and IDLE.
- The earliest next accepted `start` is the edge at T+35, i.e. the first IDLE cycle.
- Back-to-back throughput is one result per 35 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `DIV32_FASTPATH_EN`.
- **Defined**
  - Special cases are detected in IDLE and jump directly to DONE with the mandated results loaded.
  - `valid` rises at T+1; `busy` is never asserted for them.
- **Undefined**
  - Special cases run the full CALC/FIX path.
  - FIX forces the mandated values, so results are identical but latency is 34 cycles.

## Test plan
- **Unsigned divide:** `signed_op`=0, a=100, b=7, `start` at T → `valid` at T+34, `quo`=14, `rem`=2; `busy` high T+1..T+33.
- **Signed, mixed signs:** a=0xFFFFFFF9 (−7), b=2 → `quo`=0xFFFFFFFD (−3), `rem`=0xFFFFFFFF (−1).
- **Divide by zero:** a=5, b=0, for both `signed_op` values → `quo`=0xFFFFFFFF, `rem`=5.
  - Latency T+1 with `DIV32_FASTPATH_EN` defined, T+34 without.
- **Signed overflow:** a=0x80000000, b=0xFFFFFFFF → `quo`=0x80000000, `rem`=0.
  - Signed case only; unsigned, the same operands give `quo`=0, `rem`=0x80000000.
- **Start while busy:** a second `start` (a=9, b=3) at T+10 → ignored; the first result is unchanged at T+34; no second `valid`.
- **Reset mid-operation:** deassert `rst_n` at T+15 → outputs immediately 0 and state IDLE.
  - After release, a=9, b=3 gives `quo`=3, `rem`=0 after 34 cycles.

Source files
------------

// File: rtl/div32_seq.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU with start/valid handshake.
// Optional macro DIV32_FASTPATH_EN: divide-by-zero and signed overflow complete directly from IDLE.
module div32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        valid,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [32:0] p;
    logic [31:0] q;
    logic [31:0] dvs;
    logic [31:0] a_raw;
    logic        neg_q, neg_r, div0, ovf;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        in_div0, in_ovf;
    logic [32:0] p_shift, p_step;
    logic        ge;
    logic [31:0] q_step;
    logic [31:0] quo_fix, rem_fix;
    logic        fast_go;
`ifdef DIV32_FASTPATH_EN
    logic [31:0] fast_quo, fast_rem;
`endif

    always_comb begin
        a_neg   = signed_op & a[31];
        b_neg   = signed_op & b[31];
        a_abs   = a_neg ? (32'd0 - a) : a;
        b_abs   = b_neg ? (32'd0 - b) : b;
        in_div0 = (b == '0);
        in_ovf  = signed_op && (a == 32'h8000_0000) && (b == '1);

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        p_shift = {p[31:0], q[31]};
        ge      = (p_shift >= {1'b0, dvs});
        p_step  = ge ? (p_shift - {1'b0, dvs}) : p_shift;
        q_step  = {q[30:0], ge};

        // Mandated special-case results override the sign-corrected magnitudes.
        if (div0) begin
            quo_fix = '1;
            rem_fix = a_raw;
        end else if (ovf) begin
            quo_fix = 32'h8000_0000;
            rem_fix = '0;
        end else begin
            quo_fix = neg_q ? (32'd0 - q) : q;
            rem_fix = neg_r ? (32'd0 - p[31:0]) : p[31:0];
        end

`ifdef DIV32_FASTPATH_EN
        fast_go  = in_div0 | in_ovf;
        fast_quo = in_div0 ? '1 : 32'h8000_0000;
        fast_rem = in_div0 ? a : '0;
`else
        fast_go  = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = fast_go ? DONE : CALC;
            CALC: if (cnt == 5'd0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= '0;
            q     <= '0;
            dvs   <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CALC) || (state_nxt == FIX);
            valid <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs   <= b_abs;
                        p     <= '0;
                        q     <= a_abs;
                        a_raw <= a;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        div0  <= in_div0;
                        ovf   <= in_ovf;
                        cnt   <= 5'd31;
`ifdef DIV32_FASTPATH_EN
                        if (fast_go) begin
                            quo <= fast_quo;
                            rem <= fast_rem;
                        end
`endif
                    end
                end
                CALC: begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt - 5'd1;
                end
                FIX: begin
                    quo <= quo_fix;
                    rem <= rem_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed scoreboard bench for div32_seq; honours DIV32_FASTPATH_EN for special-case latency.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, valid;
    logic [31:0] quo, rem;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        fast;
    } exp_t;

    exp_t sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    div32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .valid     (valid),
        .quo       (quo),
        .rem       (rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic sop, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int unsigned inject_at, input string tag);
        exp_t        e;
        logic        got_valid;
        logic        busy_ok;
        logic        exp_busy;
        int unsigned lat;
        int unsigned exp_lat;
        e.q = eq;
        e.r = er;
`ifdef DIV32_FASTPATH_EN
        e.fast = (bv == 32'd0) || (sop && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
`else
        e.fast = 1'b0;
`endif
        sb.push_back(e);
        @(negedge clk);
        signed_op = sop;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0001;
        signed_op = ~sop;
        got_valid = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == inject_at) begin
                start = 1'b1;
                a = 32'd9;
                b = 32'd3;
                signed_op = 1'b0;
            end else begin
                start = 1'b0;
            end
            exp_busy = !e.fast && (k <= 33);
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (valid === 1'b1) begin
                got_valid = 1'b1;
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, " valid_seen"}, {31'd0, got_valid}, 32'd1);
        check({tag, " busy_profile"}, {31'd0, busy_ok}, 32'd1);
        if (got_valid) begin
            exp_lat = sb[0].fast ? 1 : 34;
            check({tag, " latency"}, lat, exp_lat);
            e = sb.pop_front();
            check({tag, " quo"}, quo, e.q);
            check({tag, " rem"}, rem, e.r);
            @(negedge clk);
            check({tag, " valid_pulse"}, {31'd0, valid}, 32'd0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int unsigned extra_valid;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset quo", quo, 32'd0);
        check("reset rem", rem, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "udiv_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "sdiv_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, "sdiv_7_m2");
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0, "sdiv_m100_m7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, "udiv_max_1");
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, "udiv_by0");
        run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, "sdiv_by0");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, "sdiv_neg_by0");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, "sdiv_ovf");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, "udiv_ovf_ops");

        // Second start at T+10 must be dropped entirely.
        run_op(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 10, "start_while_busy");
        extra_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid === 1'b1) extra_valid++;
        end
        check("no_second_valid", extra_valid, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        signed_op = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset valid", {31'd0, valid}, 32'd0);
        check("midreset quo", quo, 32'd0);
        check("midreset rem", rem, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) extra_valid++;
        end
        check("midreset discarded", extra_valid, 32'd0);
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, "post_reset_9_3");

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
